// File: rtl/counter_fnd_ctrl_n.sv
// counter_fnd_ctrl_n: N-digit BCD up/down counter with debounced buttons and multiplexed FND driver
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit0.
module counter_fnd_ctrl_n #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 33554432,
    parameter int DEB_DIV  = 131072,
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                btn_dir,
    input  logic                btn_run,
    input  logic                btn_clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                up,
    output logic                run,
    output logic                wrap,
    output logic [DIGITS-1:0]   com,
    output logic [7:0]          seg_7
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [TW-1:0]       presc;
    logic [DW-1:0]       deb_cnt;
    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       idx;
    logic [2:0]          raw, smp, deb, deb_q, press;
    logic                tick, deb_stb, carry, borrow;
    logic [3:0]          nib, sel;
    logic [4*DIGITS-1:0] inc, dec, ld;
    logic [DIGITS-1:0]   blank;
    logic [6:0]          font;
`ifdef LEADING_ZERO_BLANK_EN
    logic                z;
`endif

    // bit order {clr, run, dir}
    assign raw     = {btn_clr, btn_run, btn_dir};
    assign press   = deb & ~deb_q;
    assign tick    = run && presc == TW'(TICK_DIV - 1);
    assign deb_stb = deb_cnt == DW'(DEB_DIV - 1);

    always_comb begin
        carry  = 1'b1;
        borrow = 1'b1;
        nib    = '0;
        inc    = '0;
        dec    = '0;
        ld     = '0;
        blank  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_bcd[4*i +: 4];
            inc[4*i +: 4] = carry ? (nib == 4'd9 ? 4'd0 : nib + 4'd1) : nib;
            dec[4*i +: 4] = borrow ? (nib == 4'd0 ? 4'd9 : nib - 4'd1) : nib;
            carry  = carry && nib == 4'd9;
            borrow = borrow && nib == 4'd0;
            ld[4*i +: 4] = load_value[4*i +: 4] > 4'd9 ? 4'd9 : load_value[4*i +: 4];
        end
`ifdef LEADING_ZERO_BLANK_EN
        z = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z = z && count_bcd[4*i +: 4] == 4'd0;
            blank[i] = z;
        end
`endif
    end

    always_comb begin
        sel = count_bcd[{idx, 2'b00} +: 4];
        case (sel)
            4'd0:    font = 7'h40;
            4'd1:    font = 7'h79;
            4'd2:    font = 7'h24;
            4'd3:    font = 7'h30;
            4'd4:    font = 7'h19;
            4'd5:    font = 7'h12;
            4'd6:    font = 7'h02;
            4'd7:    font = 7'h78;
            4'd8:    font = 7'h00;
            4'd9:    font = 7'h10;
            default: font = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            deb_cnt   <= '0;
            smp       <= '0;
            deb       <= '0;
            deb_q     <= '0;
            presc     <= '0;
            count_bcd <= '0;
            up        <= 1'b1;
            run       <= 1'b1;
            wrap      <= 1'b0;
            scan_cnt  <= '0;
            idx       <= '0;
            com       <= ~DIGITS'(1);
            seg_7     <= 8'hC0;
        end else begin
            deb_cnt <= deb_stb ? '0 : deb_cnt + 1'b1;
            if (deb_stb) begin
                smp <= raw;
                deb <= ((smp ~^ raw) & raw) | ((smp ^ raw) & deb);
            end
            deb_q <= deb;
            up    <= up ^ press[0];
            run   <= run ^ press[1];
            if (press[2])
                presc <= '0;
            else if (run)
                presc <= tick ? '0 : presc + 1'b1;
            count_bcd <= press[2] ? '0 : load ? ld : tick ? (up ? inc : dec) : count_bcd;
            wrap      <= !press[2] && !load && tick && (up ? carry : borrow);
            scan_cnt  <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + 1'b1;
            if (scan_cnt == SW'(SCAN_DIV - 1))
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            com   <= ~(DIGITS'(1) << idx);
            seg_7 <= blank[idx] ? 8'hFF : {~(idx == '0 && !up), font};
        end
    end
endmodule
